// File: rtl/timer_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding and prescaler sizing.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_CLK_DIV = 50000000;

  // Counter width needed to hold 0..div-1 (div >= 2).
  function automatic int pre_width(input int div);
    return $clog2(div);
  endfunction

  localparam int PRE_W_DEF = pre_width(DEF_CLK_DIV);

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a registered one-cycle tick every CLK_DIV enabled cycles.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = pre_width(CLK_DIV);
  localparam logic [W-1:0] CNT_MAX = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      tick_d = (cnt_q == CNT_MAX);
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one interval timer among N_REQ requesters.
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 8,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] load_val,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       remaining,
  output logic                   tick
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win;
  logic               pre_en, pre_clr, pre_tick;

  // Search starts just after the last served index, so a requester that keeps
  // req high goes to the back of the line.
  always_comb begin
    win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % N_REQ]) win = IDX_W'((int'(last_q) + k) % N_REQ);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    rem_d   = rem_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d      = ST_RUN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          rem_d        = load_val[int'(win)*CNT_W +: CNT_W];
        end
      end
      ST_RUN: begin
        // Abort is checked first so it beats a coincident tick.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rem_d   = '0;
          last_d  = owner_q;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else if (pre_tick) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        rem_d   = '0;
        last_d  = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        rem_d   = '0;
      end
    endcase
  end

  // Prescaler only counts while staying in RUN; any entry or exit restarts it.
  assign pre_en  = (state_q == ST_RUN);
  assign pre_clr = (state_q != ST_RUN) || (state_d != ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      rem_q   <= rem_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_pre (
    .clk    (clk),
    .reset  (reset),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (pre_tick)
  );

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;
  assign tick      = pre_tick;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with CLK_DIV=4, N_REQ=4, CNT_W=8.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic [N-1:0]   grant, done;
  logic           busy, tick;
  logic [W-1:0]   remaining;

  int n_cmp = 0;
  int n_err = 0;

  timer_arbiter #(.N_REQ(N), .CNT_W(W), .CLK_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .load_val  (load_val),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic ld(input int i, input logic [W-1:0] v);
    load_val[i*W +: W] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_rem"}, 32'(remaining), 32'd0);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    req = '0;
    load_val = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    step();

    // Single request, load 3; load changed to 9 mid-run must not matter.
    req = 4'b0001;
    ld(0, 8'd3);
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 3) ld(0, 8'd9);
      chk($sformatf("s1_tick_c%0d", c), 32'(tick), 32'((c == 5 || c == 9 || c == 13) ? 1 : 0));
      chk($sformatf("s1_done_c%0d", c), 32'(done), 32'((c == 14) ? 1 : 0));
      chk($sformatf("s1_grant_c%0d", c), 32'(grant), 32'((c <= 14) ? 1 : 0));
      if (c == 1)  chk("s1_rem_c1", 32'(remaining), 32'd3);
      if (c == 6)  chk("s1_rem_c6", 32'(remaining), 32'd2);
      if (c == 10) chk("s1_rem_c10", 32'(remaining), 32'd1);
      if (c == 14) begin
        chk("s1_rem_c14", 32'(remaining), 32'd0);
        chk("s1_busy_c14", 32'(busy), 32'd1);
        req = '0;
      end
      if (c == 15) chk("s1_busy_c15", 32'(busy), 32'd0);
    end

    // Contention from a fresh reset: order 0,1,2,3,0.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < N; i++) ld(i, 8'd1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 20 && grant == '0; b++) step();
      chk($sformatf("s2_grant_%0d", i), 32'(grant), 32'(1) << order[i]);
      for (int b = 0; b < 20 && done == '0; b++) step();
      chk($sformatf("s2_done_%0d", i), 32'(done), 32'(1) << order[i]);
      chk($sformatf("s2_grant_in_done_%0d", i), 32'(grant), 32'(1) << order[i]);
      if (i == 4) req = '0;
      step();
      chk($sformatf("s2_done_pulse_%0d", i), 32'(done), 32'd0);
      chk($sformatf("s2_grant_idle_%0d", i), 32'(grant), 32'd0);
    end

    // Zero interval on requester 2.
    ld(2, 8'd0);
    req = 4'b0100;
    step();
    chk("s3_grant", 32'(grant), 32'h4);
    chk("s3_done0", 32'(done), 32'd0);
    chk("s3_tick0", 32'(tick), 32'd0);
    chk("s3_busy", 32'(busy), 32'd1);
    step();
    chk("s3_done", 32'(done), 32'h4);
    chk("s3_grant_held", 32'(grant), 32'h4);
    chk("s3_tick1", 32'(tick), 32'd0);
    req = '0;
    step();
    chk("s3_grant_off", 32'(grant), 32'd0);
    chk("s3_tick2", 32'(tick), 32'd0);

    // Abort of requester 1 on the cycle of its 2nd tick; requester 2 waits.
    ld(1, 8'd5);
    ld(2, 8'd2);
    req = 4'b0110;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("s4_tick_c%0d", c), 32'(tick), 32'((c == 5 || c == 9) ? 1 : 0));
      chk($sformatf("s4_done_c%0d", c), 32'(done), 32'd0);
      if (c <= 9) chk($sformatf("s4_grant_c%0d", c), 32'(grant), 32'h2);
      if (c == 9) begin
        chk("s4_rem_c9", 32'(remaining), 32'd4);
        req = 4'b0100;
      end
    end
    chk_all_zero("s4_abort");
    step();
    chk("s4_next_grant", 32'(grant), 32'h4);
    chk("s4_next_rem", 32'(remaining), 32'd2);
    for (int b = 0; b < 20 && done == '0; b++) step();
    chk("s4_next_done", 32'(done), 32'h4);
    req = '0;
    step();
    chk("s4_idle", 32'(grant), 32'd0);

    // Reset mid-run with 4 ticks left, then a fresh grant with the full load.
    ld(0, 8'd6);
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) step();
    chk("s5_grant_pre", 32'(grant), 32'h1);
    chk("s5_rem_pre", 32'(remaining), 32'd4);
    reset = 1'b0;
    #1;
    chk_all_zero("s5_async");
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    step();
    chk("s5_regrant", 32'(grant), 32'h1);
    chk("s5_reload", 32'(remaining), 32'd6);
    chk("s5_busy", 32'(busy), 32'd1);
    req = '0;
    step();
    chk("s5_abort_grant", 32'(grant), 32'd0);
    chk("s5_abort_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
